// File: rtl/noc_mem_responder.sv
// NoC memory responder: pops one request packet, performs one line access, pushes one response.
// Optional memory-ack timeout is compiled in when NOC_RESP_TIMEOUT_EN is defined.
module noc_mem_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic         ipclk,
    input  logic         rst,
    input  logic [3:0]   prt_addr,
    input  logic [3:0]   prt_num,
    input  logic         rx_av,
    output logic         rx_re,
    input  logic [287:0] rx_dat,
    output logic         tx_av,
    input  logic         tx_re,
    output logic [287:0] tx_dat,
    output logic         mem_req,
    output logic         mem_we,
    output logic [27:0]  mem_addr,
    output logic [15:0]  mem_be,
    output logic [127:0] mem_wdat,
    input  logic         mem_ack,
    input  logic [127:0] mem_rdat,
    output logic         busy
);
    localparam int unsigned PKT_W = 288;
    localparam int unsigned HDR_W = 192;   // 8 header bytes plus at most 16 data bytes
    localparam int unsigned LANES = 16;

    typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

    state_t           state;
    logic [HDR_W-1:0] req_q;
    logic [7:0]       port_id;
    logic             mem_timeout;
    logic             unused_rx;

    assign port_id   = {prt_addr, prt_num};
    assign rx_re     = (state == IDLE) && rx_av && !rst;
    assign unused_rx = ^rx_dat[PKT_W-1:HDR_W];

`ifdef NOC_RESP_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    assign mem_timeout = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unsigned UNUSED_TMO = TIMEOUT_CYCLES;
    assign mem_timeout = 1'b0;
`endif

    // Malformed request: illegal op, bad count, line overrun or length mismatch.
    function automatic logic req_error(input logic [HDR_W-1:0] p);
        logic [1:0] op;
        logic [4:0] cnt;
        logic [4:0] end_lane;
        op       = p[31:30];
        cnt      = p[28:24];
        end_lane = 5'(p[35:32]) + cnt;
        req_error = op[1] || (cnt == 5'd0) || (cnt > 5'd16) || (end_lane > 5'd16)
                  || (!op[0] && (p[7:0] != 8'd8))
                  || (op[0] && (p[7:0] != (8'd8 + 8'(cnt))));
    endfunction

    function automatic logic [LANES-1:0] req_be(input logic [HDR_W-1:0] p);
        req_be = 16'(((32'd1 << p[28:24]) - 32'd1) << p[35:32]);
    endfunction

    // Write data placed on lanes offset..offset+count-1; reads carry no data.
    function automatic logic [127:0] req_wdat(input logic [HDR_W-1:0] p);
        int unsigned off;
        int unsigned cnt;
        off = 32'(p[35:32]);
        cnt = 32'(p[28:24]);
        req_wdat = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (p[30] && (i >= off) && ((i - off) < cnt))
                req_wdat[8*i +: 8] = p[8*(8 + i - off) +: 8];
        end
    endfunction

    function automatic logic [PKT_W-1:0] resp_pkt(input logic [HDR_W-1:0] p,
                                                  input logic [127:0]     rdat,
                                                  input logic             err,
                                                  input logic [7:0]       me);
        int unsigned off;
        int unsigned cnt;
        logic        rd_ok;
        off   = 32'(p[35:32]);
        cnt   = 32'(p[28:24]);
        rd_ok = !p[30] && !err;
        resp_pkt         = '0;
        resp_pkt[7:0]    = rd_ok ? (8'd8 + 8'(cnt)) : 8'd8;
        resp_pkt[15:8]   = p[23:16];
        resp_pkt[23:16]  = me;
        resp_pkt[31:24]  = {p[31:30], err, p[28:24]};
        resp_pkt[63:32]  = p[63:32];
        for (int unsigned k = 0; k < LANES; k++) begin
            if (rd_ok && (k < cnt))
                resp_pkt[8*(8 + k) +: 8] = rdat[8*(off + k) +: 8];
        end
    endfunction

    always_ff @(posedge ipclk) begin
        if (rst) begin
            state    <= IDLE;
            req_q    <= '0;
            tx_av    <= 1'b0;
            tx_dat   <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_be   <= '0;
            mem_wdat <= '0;
            busy     <= 1'b0;
`ifdef NOC_RESP_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rx_av) begin
                        req_q <= rx_dat[HDR_W-1:0];
                        busy  <= 1'b1;
                        if (req_error(rx_dat[HDR_W-1:0])) begin
                            state  <= RESP;
                            tx_av  <= 1'b1;
                            tx_dat <= resp_pkt(rx_dat[HDR_W-1:0], '0, 1'b1, port_id);
                        end else begin
                            state    <= MEM;
                            mem_req  <= 1'b1;
                            mem_we   <= rx_dat[30];
                            mem_addr <= rx_dat[63:36];
                            mem_be   <= req_be(rx_dat[HDR_W-1:0]);
                            mem_wdat <= req_wdat(rx_dat[HDR_W-1:0]);
`ifdef NOC_RESP_TIMEOUT_EN
                            tmo_cnt  <= '0;
`endif
                        end
                    end
                end
                MEM: begin
                    // An ack on the expiry edge wins, so the error flag is simply !mem_ack.
                    if (mem_ack || mem_timeout) begin
                        state    <= RESP;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_addr <= '0;
                        mem_be   <= '0;
                        mem_wdat <= '0;
                        tx_av    <= 1'b1;
                        tx_dat   <= resp_pkt(req_q, mem_rdat, !mem_ack, port_id);
                    end
`ifdef NOC_RESP_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
                end
                RESP: begin
                    if (tx_re) begin
                        state  <= IDLE;
                        tx_av  <= 1'b0;
                        tx_dat <= '0;
                        busy   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_noc_mem_responder.sv
// Randomized self-checking bench for noc_mem_responder against a byte-level reference model.
module tb_noc_mem_responder;
`ifdef NOC_RESP_TIMEOUT_EN
    localparam int unsigned TMO     = 4;
    localparam int          TMO_LIM = 4;
`else
    localparam int unsigned TMO     = 256;
    localparam int          TMO_LIM = 1000000;
`endif
    localparam logic [3:0] PA = 4'hA;
    localparam logic [3:0] PN = 4'h5;

    logic         ipclk = 1'b0;
    logic         rst;
    logic         rx_av, rx_re, tx_av, tx_re;
    logic [287:0] rx_dat, tx_dat;
    logic         mem_req, mem_we, mem_ack, busy;
    logic [27:0]  mem_addr;
    logic [15:0]  mem_be;
    logic [127:0] mem_wdat, mem_rdat;

    int           total = 0;
    int           bad   = 0;
    logic [287:0] last_tx;
    logic [15:0]  last_be;
    logic [27:0]  last_addr;
    logic [127:0] last_wdat;

    always #5 ipclk = ~ipclk;

    noc_mem_responder #(.TIMEOUT_CYCLES(TMO)) dut (
        .ipclk(ipclk), .rst(rst), .prt_addr(PA), .prt_num(PN),
        .rx_av(rx_av), .rx_re(rx_re), .rx_dat(rx_dat),
        .tx_av(tx_av), .tx_re(tx_re), .tx_dat(tx_dat),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdat(mem_wdat), .mem_ack(mem_ack), .mem_rdat(mem_rdat), .busy(busy)
    );

    task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pb(input logic [287:0] p, input int j);
        return p[8*j +: 8];
    endfunction

    function automatic logic [287:0] mk_pkt(input logic [7:0] len, input logic [7:0] dst,
                                            input logic [7:0] src, input logic [7:0] cmd,
                                            input logic [31:0] addr, input logic [127:0] data);
        return {96'b0, data, addr, cmd, src, dst, len};
    endfunction

    function automatic bit m_err(input logic [287:0] p);
        int len, op, cnt, off;
        len = int'(pb(p, 0));
        op  = int'(pb(p, 3)) / 64;
        cnt = int'(pb(p, 3)) % 32;
        off = int'(pb(p, 4)) % 16;
        return (op > 1) || (cnt == 0) || (cnt > 16) || (off + cnt > 16)
            || (op == 0 && len != 8) || (op == 1 && len != 8 + cnt);
    endfunction

    function automatic logic [27:0] m_addr(input logic [287:0] p);
        logic [31:0] a;
        a = {pb(p, 7), pb(p, 6), pb(p, 5), pb(p, 4)};
        return 28'(a / 32'd16);
    endfunction

    function automatic logic [15:0] m_be(input logic [287:0] p);
        int be, cnt, off;
        cnt = int'(pb(p, 3)) % 32;
        off = int'(pb(p, 4)) % 16;
        be  = 0;
        for (int k = 0; k < cnt; k++) be += 1 << (off + k);
        return 16'(be);
    endfunction

    function automatic logic [127:0] m_wdat(input logic [287:0] p);
        logic [7:0]   lane [16];
        logic [127:0] v;
        int           cnt, off;
        cnt = int'(pb(p, 3)) % 32;
        off = int'(pb(p, 4)) % 16;
        for (int i = 0; i < 16; i++) lane[i] = 8'h00;
        if (int'(pb(p, 3)) / 64 == 1)
            for (int k = 0; k < cnt; k++) lane[off + k] = pb(p, 8 + k);
        for (int i = 0; i < 16; i++) v[8*i +: 8] = lane[i];
        return v;
    endfunction

    function automatic logic [287:0] m_resp(input logic [287:0] p, input logic [127:0] rdat, input bit tmo);
        logic [7:0]   r [36];
        logic [287:0] v;
        bit           err;
        int           op, cnt, off;
        err = m_err(p) || tmo;
        op  = int'(pb(p, 3)) / 64;
        cnt = int'(pb(p, 3)) % 32;
        off = int'(pb(p, 4)) % 16;
        for (int j = 0; j < 36; j++) r[j] = 8'h00;
        r[0] = (op == 0 && !err) ? 8'(8 + cnt) : 8'd8;
        r[1] = pb(p, 2);
        r[2] = {PA, PN};
        r[3] = 8'(op * 64 + (err ? 32 : 0) + cnt);
        for (int j = 4; j < 8; j++) r[j] = pb(p, j);
        if (op == 0 && !err)
            for (int k = 0; k < cnt; k++) r[8 + k] = rdat[8*(off + k) +: 8];
        for (int j = 0; j < 36; j++) v[8*j +: 8] = r[j];
        return v;
    endfunction

    // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
    task automatic run_txn(input logic [287:0] p, input int delay, input int bp,
                           input logic [127:0] rdat, input bit chain, input logic [287:0] nxt);
        bit           err, tmo;
        int           waits;
        logic [287:0] exp_tx;
        err    = m_err(p);
        tmo    = !err && (delay >= TMO_LIM);
        waits  = tmo ? TMO_LIM : delay;
        exp_tx = m_resp(p, rdat, tmo);
        rx_av  = 1'b1;
        rx_dat = p;
        #1;
        chk("rx_re_idle", 288'(rx_re), 288'(1));
        @(negedge ipclk);
        rx_av = 1'b0;
        #1;
        chk("busy_after_pop", 288'(busy), 288'(1));
        chk("rx_re_busy", 288'(rx_re), 288'(0));
        if (err) begin
            chk("err_no_mem_req", 288'(mem_req), 288'(0));
        end else begin
            last_addr = mem_addr;
            last_be   = mem_be;
            last_wdat = mem_wdat;
            chk("mem_addr", 288'(mem_addr), 288'(m_addr(p)));
            chk("mem_be", 288'(mem_be), 288'(m_be(p)));
            chk("mem_we", 288'(mem_we), 288'(pb(p, 3) / 8'd64 == 8'd1));
            chk("mem_wdat", 288'(mem_wdat), 288'(m_wdat(p)));
            for (int i = 0; i < waits; i++) begin
                chk("mem_req_hold", 288'(mem_req), 288'(1));
                chk("no_tx_in_mem", 288'(tx_av), 288'(0));
                @(negedge ipclk);
            end
            if (!tmo) begin
                chk("mem_req_at_ack", 288'(mem_req), 288'(1));
                mem_ack  = 1'b1;
                mem_rdat = rdat;
                @(negedge ipclk);
                mem_ack  = 1'b0;
                mem_rdat = {$urandom, $urandom, $urandom, $urandom};
            end
            chk("mem_req_drop", 288'(mem_req), 288'(0));
        end
        chk("tx_av", 288'(tx_av), 288'(1));
        chk("tx_dat", tx_dat, exp_tx);
        last_tx = tx_dat;
        if (chain) begin
            rx_av  = 1'b1;
            rx_dat = nxt;
        end
        for (int i = 0; i < bp; i++) begin
            #1;
            if (chain) chk("rx_re_in_resp", 288'(rx_re), 288'(0));
            @(negedge ipclk);
            chk("tx_av_held", 288'(tx_av), 288'(1));
            chk("tx_dat_held", tx_dat, exp_tx);
        end
        tx_re = 1'b1;
        @(negedge ipclk);
        tx_re = 1'b0;
        chk("tx_av_clear", 288'(tx_av), 288'(0));
        chk("busy_clear", 288'(busy), 288'(0));
    endtask

    initial begin
        logic [287:0] p, p2;
        logic [127:0] r;
        int           op, cnt, off, len, kind, dly;
        logic [31:0]  a;
        logic [7:0]   cmd;

        rst      = 1'b1;
        rx_av    = 1'b1;
        rx_dat   = mk_pkt(8'd8, 8'h00, 8'h00, 8'h01, 32'h0, '0);
        tx_re    = 1'b1;
        mem_ack  = 1'b1;
        mem_rdat = '0;
        repeat (3) @(negedge ipclk);
        chk("rst_rx_re", 288'(rx_re), 288'(0));
        chk("rst_outs", 288'({tx_av, mem_req, mem_we, busy}), 288'(0));
        chk("rst_mem_bus", 288'({mem_addr, mem_be, mem_wdat}), 288'(0));
        chk("rst_tx_dat", tx_dat, 288'(0));
        rx_av = 1'b0;
        tx_re = 1'b0;
        rst   = 1'b0;
        @(negedge ipclk);
        mem_ack = 1'b0;
        chk("idle_ack_ignored", 288'({busy, tx_av, mem_req}), 288'(0));

        // Write with offset 2, ack after 3 cycles
        p = mk_pkt(8'd12, 8'h33, 8'h21, 8'h44, 32'h0000_1002, {96'b0, 32'hEFBE_ADDE});
        run_txn(p, 3, 0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
        chk("w_be", 288'(last_be), 288'(16'h003C));
        chk("w_addr", 288'(last_addr), 288'(28'h0000100));
        chk("w_lanes", 288'(last_wdat[47:16]), 288'(32'hEFBE_ADDE));
        chk("w_len", 288'(last_tx[7:0]), 288'(8));
        chk("w_b3", 288'(last_tx[31:24]), 288'(8'h44));

        // Read of the top two lanes
        r = {$urandom, $urandom, $urandom, $urandom};
        r[127:112] = 16'h2211;
        p = mk_pkt(8'd8, 8'h33, 8'h47, 8'h02, 32'h0000_000E, {$urandom, $urandom, $urandom, $urandom});
        run_txn(p, 0, 0, r, 1'b0, '0);
        chk("r_len", 288'(last_tx[7:0]), 288'(10));
        chk("r_b3", 288'(last_tx[31:24]), 288'(8'h02));
        chk("r_data", 288'(last_tx[79:64]), 288'(16'h2211));

        // Line overrun is rejected without a memory access
        p = mk_pkt(8'd8, 8'h33, 8'h47, 8'h04, 32'h0000_000E, '0);
        run_txn(p, 0, 0, '0, 1'b0, '0);
        chk("bnd_b3", 288'(last_tx[31:24]), 288'(8'h24));
        chk("bnd_len", 288'(last_tx[7:0]), 288'(8));

        // Backpressure with a second request waiting
        p  = mk_pkt(8'd9, 8'h12, 8'h34, 8'h41, 32'hABCD_0007, {$urandom, $urandom, $urandom, $urandom});
        p2 = mk_pkt(8'd8, 8'h12, 8'h56, 8'h10, 32'h0000_0000, '0);
        run_txn(p, 1, 5, '0, 1'b1, p2);
        run_txn(p2, 0, 0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);

        // Reset while waiting on memory, then a stray ack
        rx_av  = 1'b1;
        rx_dat = mk_pkt(8'd8, 8'h01, 8'h02, 8'h01, 32'h0000_0040, '0);
        @(negedge ipclk);
        rx_av = 1'b0;
        chk("rm_mem_req", 288'(mem_req), 288'(1));
        @(negedge ipclk);
        rst = 1'b1;
        @(negedge ipclk);
        rst = 1'b0;
        chk("rm_cleared", 288'({mem_req, busy, tx_av}), 288'(0));
        mem_ack = 1'b1;
        @(negedge ipclk);
        mem_ack = 1'b0;
        repeat (2) begin
            @(negedge ipclk);
            chk("rm_quiet", 288'({mem_req, busy, tx_av}), 288'(0));
        end

        // Slow memory: times out when the timeout is built in, otherwise waits it out
        p = mk_pkt(8'd8, 8'h10, 8'h77, 8'h03, 32'h1234_5670, '0);
        run_txn(p, 20, 1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
        chk("slow_err", 288'(last_tx[29]), 288'(TMO_LIM < 100));
        chk("slow_len", 288'(last_tx[7:0]), 288'((TMO_LIM < 100) ? 8 : 11));

        for (int n = 0; n < 80; n++) begin
            op   = int'($urandom_range(0, 1));
            cnt  = int'($urandom_range(1, 16));
            off  = int'($urandom_range(0, 16 - cnt));
            kind = int'($urandom_range(0, 9));
            if (kind == 0) op = int'($urandom_range(2, 3));
            if (kind == 1) cnt = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(17, 31));
            if (kind == 2) begin
                cnt = int'($urandom_range(2, 16));
                off = int'($urandom_range(17 - cnt, 15));
            end
            len = (op == 1) ? 8 + cnt : 8;
            if (kind == 3) len = len + 1;
            cmd = 8'(op * 64 + int'($urandom_range(0, 1)) * 32 + cnt);
            a   = $urandom;
            a[3:0] = 4'(off);
            p = mk_pkt(8'(len), 8'($urandom), 8'($urandom), cmd, a,
                       {$urandom, $urandom, $urandom, $urandom});
            p[287:192] = {$urandom, $urandom, $urandom};
            dly = ($urandom_range(0, 9) == 0) ? 6 : int'($urandom_range(0, 3));
            run_txn(p, dly, int'($urandom_range(0, 3)),
                    {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/noc_mem_responder.md
NOC_MEM_RESPONDER -- requirements
Module: noc_mem_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, memory-ack timeout in cycles (used only with NOC_RESP_TIMEOUT_EN).
REQ-002 SHALL use one clock and a synchronous, active-high reset: ipclk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 prt_addr  input  4  NIU address of the attached port.
REQ-005 prt_num  input  4  port number of the attached port.
REQ-006 rx_av / rx_re / rx_dat  input 1 / output 1 / input 288  request queue: head valid, pop, head packet (show-ahead).
REQ-007 tx_av / tx_re / tx_dat  output 1 / input 1 / output 288  response queue: push, not-full, packet.
REQ-008 mem_req / mem_we / mem_addr / mem_be / mem_wdat  output 1 / 1 / 28 / 16 / 128  memory request: line address, byte enables, write data.
REQ-009 mem_ack / mem_rdat  input 1 / 128  memory completion and read data, valid on the mem_ack cycle.
REQ-010 busy  output 1  high whenever state != IDLE.

Function
REQ-011 Packet byte j SHALL be dat[8j+7:8j]: byte0 length, byte1 dst {addr,port}, byte2 src {addr,port}, byte3 cmd, bytes4-7 address (little-endian), bytes 8+ data (max 16).
REQ-012 cmd fields SHALL be: [7:6] op (00 read, 01 write, 1x illegal); [4:0] count.
REQ-013 States SHALL be IDLE, MEM, RESP.
REQ-014 In IDLE, rx_re SHALL equal rx_av, and the packet SHALL be captured at the same edge; rx_re SHALL be 0 in other states.
REQ-015 Error is set if any of the following hold: op illegal; count = 0; count > 16; offset + count > 16 (5-bit sum, offset = addr[3:0]); read length != 8; write length != 8 + count.
REQ-016 On capture: if error, IDLE->RESP; otherwise IDLE->MEM.
REQ-017 In MEM, mem_req SHALL be 1 and mem_addr = addr[31:4].
REQ-018 In MEM, mem_be = ((1<<count)-1)<<offset and mem_we = op[0].
REQ-019 In MEM, mem_wdat lane (offset+k) SHALL equal data byte k; unused lanes are 0.
REQ-020 At an edge with mem_ack in MEM: capture mem_rdat and go to RESP; mem_ack outside MEM SHALL be ignored.
REQ-021 In RESP, tx_av SHALL be 1, held until an edge with tx_re = 1, then go to IDLE.
REQ-022 tx_dat SHALL be stable from RESP entry until that edge.
REQ-023 Response byte1 SHALL be the request byte2; byte2 = {prt_addr, prt_num}.
REQ-024 Response byte3 = {op, error, count}; bytes 4-7 echo the request address.
REQ-025 A successful read response SHALL have length 8 + count, with byte 8+k = mem_rdat lane (offset+k).
REQ-026 Write and error responses SHALL have length 8; all bytes beyond the length SHALL be 0.
REQ-027 Minimum latency: capture at cycle 0, mem_req at cycle 1; with mem_ack at cycle 1 and tx_re = 1, tx_av at cycle 2, IDLE at cycle 3.
REQ-028 Error path: tx_av at cycle 1.
REQ-029 Exactly one request SHALL be outstanding; rx_av while busy is not popped.

Reset
REQ-030 At reset: state = IDLE and the captured packet is cleared.
REQ-031 At reset: rx_re, tx_av, mem_req, mem_we, busy = 0; mem_addr, mem_be, mem_wdat, tx_dat = 0.
REQ-032 Reset in MEM or RESP SHALL abandon the request with no response; outputs are 0 from the next cycle.

Configuration
REQ-033 Macro NOC_RESP_TIMEOUT_EN defined: a counter clears on MEM entry and increments each MEM cycle.
REQ-034 With the macro defined, reaching TIMEOUT_CYCLES without mem_ack SHALL drop mem_req, set error, and go to RESP with a length-8 response; mem_ack on the expiry edge takes priority.
REQ-035 Macro NOC_RESP_TIMEOUT_EN undefined: no counter; MEM waits indefinitely.

Verification
REQ-036 Write: len 12, cmd 0x44, addr 0x00001002, data DE AD BE EF, ack after 3 cycles -> mem_be 0x003C, mem_addr 0x0000100, lanes 2-5 = DE AD BE EF, response len 8, byte3 0x44.
REQ-037 Read: len 8, cmd 0x02, addr 0x0000000E, rdat lanes 14/15 = 0x11/0x22 -> response len 10, byte3 0x02, bytes 8-9 = 11 22.
REQ-038 Bounds: cmd 0x04, addr offset 0xE -> no mem_req, tx_av at cycle 1, byte3 0x24, len 8.
REQ-039 Backpressure: tx_re low for 5 cycles in RESP -> tx_av and tx_dat held, rx_re 0 while a second request waits; that request is popped the cycle after the push.
REQ-040 Reset mid-MEM, then mem_ack -> no tx_av, busy 0, mem_req 0.
REQ-041 NOC_RESP_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and no ack -> mem_req for 4 cycles, then an error response with byte3 bit5 = 1.
